rob_seq_ctrl: RTL and testbench
===============================

// Module: rob_seq_ctrl
// PURPOSE
//  Sequencing controller for the reorder buffer: owns the circular head/tail pointers and per-entry status
//  (READY/ISSUED/DONE/EXCEPTION) for ROB_ENTRIES slots. Allocates slots at dispatch, tracks issue and
//  completion, retires the head in order through a valid/ready port, and runs the flush sequence when
//  the head holds an exception. Sits between rename/dispatch, the issue queues/FUs and architectural commit.
// PARAMETERS
//  ROB_ENTRIES  128                        number of slots; power of two >= 4 (rob_pkg::ROB_ENTRIES)
//  IDX_W        $clog2(ROB_ENTRIES)        slot index width
//  PTR_W        IDX_W+1                    internal pointer width; MSB is the wrap bit
// PORTS
//  clk_in            in   1       clock, all state updates on posedge
//  rst_N_in          in   1       asynchronous, active-low reset
//  alloc_valid_in    in   1       dispatch requests one slot
//  alloc_ready_out   out  1       slot available (accepting)
//  alloc_ptr_out     out  IDX_W   index granted on alloc handshake (= tail[IDX_W-1:0])
//  issue_valid_in    in   1       uop at issue_ptr_in sent to an FU
//  issue_ptr_in      in   IDX_W   slot being issued
//  cmpl_valid_in     in   1       FU writeback
//  cmpl_ptr_in       in   IDX_W   slot completing
//  cmpl_exc_in       in   1       completion raised an exception
//  commit_valid_out  out  1       head slot is DONE and retirable
//  commit_ptr_out    out  IDX_W   head index
//  commit_ready_in   in   1       commit stage accepts head this cycle
//  flush_out         out  1       one-cycle pipeline flush pulse
//  flush_ptr_out     out  IDX_W   index of the excepting slot, valid with flush_out
//  redirect_ack_in   in   1       front end redirected; dispatch may resume
//  count_out         out  PTR_W   occupied slots, 0..ROB_ENTRIES
//  empty_out/full_out out 1 each  count_out==0 / count_out==ROB_ENTRIES
// BEHAVIOUR
//  - Reset: head=tail=0, all entries invalid, state RUN; every output 0 except alloc_ready_out=1, empty_out=1.
//  - Status is internal state; commit_valid_out and the full/empty/count outputs derive from registered state only.
//  - Alloc: handshake when alloc_valid_in & alloc_ready_out; slot -> valid, READY; tail+1 (wraps, wrap bit flips).
//    alloc_ready_out = (state==RUN) & ~full. Full computed from registered pointers: a same-cycle commit does
//    NOT open a slot for the same cycle's alloc.
//  - Issue: valid slot in READY -> ISSUED; any other status/invalid slot: ignored.
//  - Completion: valid slot in READY or ISSUED -> DONE (cmpl_exc_in=0) or EXCEPTION (=1). Invalid slot or
//    already DONE/EXCEPTION: ignored. Issue and completion to the same slot same cycle: completion wins.
//  - Commit: commit_valid_out = (state==RUN) & head valid & status==DONE. On commit_valid_out & commit_ready_in:
//    slot invalid, head+1. Completion to the head in the same cycle is visible next cycle (one-cycle min latency
//    from completion to commit_valid_out). commit_valid_out may drop only on flush; it never stays high on empty.
//  - Simultaneous alloc + commit: count unchanged; both pointers advance.
//  - count = tail - head (PTR_W modular); full when indices equal and wrap bits differ; empty when pointers equal.
//  - FSM: RUN -> FLUSH when head valid & status==EXCEPTION (no commit that cycle).
//    FLUSH (1 cycle): flush_out=1, flush_ptr_out=head idx; all entries invalid; tail<=head; alloc blocked. -> WAIT.
//    WAIT: alloc blocked; completions/issues ignored; on redirect_ack_in -> RUN (alloc allowed next cycle).
//    redirect_ack_in outside WAIT is ignored.
//  - Reset asserted mid-operation (any state) returns immediately to the reset state above; no flush pulse.
// CONFIGURATION
//  ROB_PERF_CNT_EN defined: adds outputs perf_commits_out[31:0] (+1 per commit handshake) and
//    perf_flushes_out[31:0] (+1 per FLUSH cycle); both wrap at 2^32, reset to 0.
//  ROB_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, alloc 3 (ptrs 0,1,2), complete 1,0,2 no exc, commit_ready_in=1 -> commits 0,1,2 in order, count 3->0.
//  2 Alloc 128 with no commit -> full_out=1, alloc_ready_out=0, count_out=128; 129th request stalls.
//  3 Full ROB, head DONE, alloc_valid+commit_ready same cycle -> commit only; alloc granted next cycle at idx 0 (wrap).
//  4 Alloc 4, complete slot 0 with cmpl_exc_in=1 -> flush_out 1 cycle, flush_ptr_out=0, count 0, no alloc until
//    redirect_ack_in; ack -> alloc_ready_out=1 next cycle.
//  5 Complete slot already DONE or unallocated slot 50 -> no status/commit change; issue after complete keeps DONE.
//  6 Assert rst_N_in in WAIT with 10 entries -> all outputs at reset values, flush_out never pulses.

Source files
------------

// File: rtl/rob_seq_ctrl.sv
// Reorder-buffer sequencing controller: circular head/tail pointers, per-slot status, in-order commit and flush.
// Optional ROB_PERF_CNT_EN adds free-running commit and flush counters.
module rob_seq_ctrl #(
    parameter  int ROB_ENTRIES = 128,
    localparam int IDX_W       = $clog2(ROB_ENTRIES),
    localparam int PTR_W       = IDX_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_N_in,
    input  logic             alloc_valid_in,
    output logic             alloc_ready_out,
    output logic [IDX_W-1:0] alloc_ptr_out,
    input  logic             issue_valid_in,
    input  logic [IDX_W-1:0] issue_ptr_in,
    input  logic             cmpl_valid_in,
    input  logic [IDX_W-1:0] cmpl_ptr_in,
    input  logic             cmpl_exc_in,
    output logic             commit_valid_out,
    output logic [IDX_W-1:0] commit_ptr_out,
    input  logic             commit_ready_in,
    output logic             flush_out,
    output logic [IDX_W-1:0] flush_ptr_out,
    input  logic             redirect_ack_in,
    output logic [PTR_W-1:0] count_out,
    output logic             empty_out,
    output logic             full_out,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]      perf_commits_out,
    output logic [31:0]      perf_flushes_out,
`endif
    output logic [1:0]       dbg_state_out
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] STAT_READY  = 2'd0;
    localparam logic [1:0] STAT_ISSUED = 2'd1;
    localparam logic [1:0] STAT_DONE   = 2'd2;
    localparam logic [1:0] STAT_EXC    = 2'd3;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [ROB_ENTRIES-1:0] r_valid;
    logic [1:0]             r_status [ROB_ENTRIES];
    logic                   r_flush;
    logic [IDX_W-1:0]       r_flush_ptr;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_full;
    logic             w_run;
    logic             w_alloc_ready;
    logic             w_alloc_fire;
    logic             w_commit_valid;
    logic             w_commit_fire;
    logic             w_issue_ok;
    logic             w_cmpl_ok;
    logic             w_head_exc;
    logic [1:0]       w_head_stat;
    logic [1:0]       w_cmpl_stat;

    assign w_head_idx     = r_head[IDX_W-1:0];
    assign w_tail_idx     = r_tail[IDX_W-1:0];
    assign w_full         = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_run          = (r_state == ST_RUN);
    assign w_head_stat    = r_status[w_head_idx];
    assign w_cmpl_stat    = r_status[cmpl_ptr_in];
    assign w_alloc_ready  = w_run && !w_full;
    assign w_alloc_fire   = alloc_valid_in && w_alloc_ready;
    assign w_commit_valid = w_run && r_valid[w_head_idx] && (w_head_stat == STAT_DONE);
    assign w_commit_fire  = w_commit_valid && commit_ready_in;
    assign w_head_exc     = w_run && r_valid[w_head_idx] && (w_head_stat == STAT_EXC);
    assign w_issue_ok     = w_run && issue_valid_in && r_valid[issue_ptr_in]
                            && (r_status[issue_ptr_in] == STAT_READY);
    assign w_cmpl_ok      = w_run && cmpl_valid_in && r_valid[cmpl_ptr_in]
                            && ((w_cmpl_stat == STAT_READY) || (w_cmpl_stat == STAT_ISSUED));

    assign alloc_ready_out  = w_alloc_ready;
    assign alloc_ptr_out    = w_tail_idx;
    assign commit_valid_out = w_commit_valid;
    assign commit_ptr_out   = w_head_idx;
    assign flush_out        = r_flush;
    assign flush_ptr_out    = r_flush_ptr;
    assign count_out        = r_tail - r_head;
    assign empty_out        = (r_head == r_tail);
    assign full_out         = w_full;
    assign dbg_state_out    = r_state;

    // The completion write follows the issue write so that completion wins on a same-slot collision.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_state     <= ST_RUN;
            r_head      <= '0;
            r_tail      <= '0;
            r_valid     <= '0;
            r_flush     <= 1'b0;
            r_flush_ptr <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) r_status[i] <= STAT_READY;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_alloc_fire) begin
                        r_valid[w_tail_idx]  <= 1'b1;
                        r_status[w_tail_idx] <= STAT_READY;
                        r_tail               <= r_tail + PTR_W'(1);
                    end
                    if (w_issue_ok) r_status[issue_ptr_in] <= STAT_ISSUED;
                    if (w_cmpl_ok) r_status[cmpl_ptr_in] <= cmpl_exc_in ? STAT_EXC : STAT_DONE;
                    if (w_commit_fire) begin
                        r_valid[w_head_idx] <= 1'b0;
                        r_head              <= r_head + PTR_W'(1);
                    end
                    if (w_head_exc) begin
                        r_state     <= ST_FLUSH;
                        r_flush     <= 1'b1;
                        r_flush_ptr <= w_head_idx;
                    end
                end
                ST_FLUSH: begin
                    r_valid <= '0;
                    r_tail  <= r_head;
                    r_flush <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (redirect_ack_in) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_commits;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_perf_commits <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_commit_fire) r_perf_commits <= r_perf_commits + 32'd1;
            if (r_state == ST_FLUSH) r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_commits_out = r_perf_commits;
    assign perf_flushes_out = r_perf_flushes;
`endif

endmodule

// File: tb/tb_rob_seq_ctrl.sv
// Bench for rob_seq_ctrl: directed scenarios plus a randomized run checked against a queue-based ROB model.
module tb_rob_seq_ctrl;

    localparam int N     = 128;
    localparam int IDX_W = 7;
    localparam int PTR_W = 8;
    localparam int S_READY = 0, S_ISSUED = 1, S_DONE = 2, S_EXC = 3;
    localparam int M_RUN = 0, M_FLUSH = 1, M_WAIT = 2;

    logic             clk_in = 1'b0;
    logic             rst_N_in = 1'b0;
    logic             alloc_valid_in = 1'b0;
    logic             alloc_ready_out;
    logic [IDX_W-1:0] alloc_ptr_out;
    logic             issue_valid_in = 1'b0;
    logic [IDX_W-1:0] issue_ptr_in = '0;
    logic             cmpl_valid_in = 1'b0;
    logic [IDX_W-1:0] cmpl_ptr_in = '0;
    logic             cmpl_exc_in = 1'b0;
    logic             commit_valid_out;
    logic [IDX_W-1:0] commit_ptr_out;
    logic             commit_ready_in = 1'b0;
    logic             flush_out;
    logic [IDX_W-1:0] flush_ptr_out;
    logic             redirect_ack_in = 1'b0;
    logic [PTR_W-1:0] count_out;
    logic             empty_out;
    logic             full_out;
    logic [1:0]       dbg_state_out;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]      perf_commits_out;
    logic [31:0]      perf_flushes_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: occupancy is a queue of slot indices, oldest first.
    int q[$];
    int m_head, m_tail, m_mode;
    bit m_valid[N];
    int m_stat[N];
    logic [IDX_W-1:0] exp_q[$];

    rob_seq_ctrl #(.ROB_ENTRIES(N)) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out), .alloc_ptr_out(alloc_ptr_out),
        .issue_valid_in(issue_valid_in), .issue_ptr_in(issue_ptr_in),
        .cmpl_valid_in(cmpl_valid_in), .cmpl_ptr_in(cmpl_ptr_in), .cmpl_exc_in(cmpl_exc_in),
        .commit_valid_out(commit_valid_out), .commit_ptr_out(commit_ptr_out), .commit_ready_in(commit_ready_in),
        .flush_out(flush_out), .flush_ptr_out(flush_ptr_out), .redirect_ack_in(redirect_ack_in),
        .count_out(count_out), .empty_out(empty_out), .full_out(full_out),
`ifdef ROB_PERF_CNT_EN
        .perf_commits_out(perf_commits_out), .perf_flushes_out(perf_flushes_out),
`endif
        .dbg_state_out(dbg_state_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bit e_ready();
        return (m_mode == M_RUN) && (q.size() < N);
    endfunction

    function automatic bit e_cv();
        return (m_mode == M_RUN) && (q.size() > 0) && (m_stat[q[0]] == S_DONE);
    endfunction

    task automatic model_reset();
        q.delete();
        m_head = 0;
        m_tail = 0;
        m_mode = M_RUN;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_stat[i]  = S_READY;
        end
    endtask

    task automatic idle_inputs();
        alloc_valid_in  = 1'b0;
        issue_valid_in  = 1'b0;
        cmpl_valid_in   = 1'b0;
        cmpl_exc_in     = 1'b0;
        commit_ready_in = 1'b0;
        redirect_ack_in = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs and apply the same event to the model.
    task automatic step();
        bit cv, rdy, exc_head;
        int ip, cp;
        cv  = e_cv();
        rdy = e_ready();
        @(posedge clk_in);
        ip = int'(issue_ptr_in);
        cp = int'(cmpl_ptr_in);
        case (m_mode)
            M_RUN: begin
                exc_head = (q.size() > 0) && (m_stat[q[0]] == S_EXC);
                if (issue_valid_in && m_valid[ip] && m_stat[ip] == S_READY) m_stat[ip] = S_ISSUED;
                if (cmpl_valid_in && m_valid[cp] && (m_stat[cp] == S_READY || m_stat[cp] == S_ISSUED))
                    m_stat[cp] = cmpl_exc_in ? S_EXC : S_DONE;
                if (cv && commit_ready_in) begin
                    m_valid[q[0]] = 1'b0;
                    void'(q.pop_front());
                    m_head = (m_head + 1) % N;
                end
                if (rdy && alloc_valid_in) begin
                    q.push_back(m_tail);
                    m_valid[m_tail] = 1'b1;
                    m_stat[m_tail]  = S_READY;
                    m_tail = (m_tail + 1) % N;
                end
                if (exc_head) m_mode = M_FLUSH;
            end
            M_FLUSH: begin
                q.delete();
                for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
                m_tail = m_head;
                m_mode = M_WAIT;
            end
            default: if (redirect_ack_in) m_mode = M_RUN;
        endcase
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        idle_inputs();
        rst_N_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_N_in = 1'b1;
        step();
    endtask

    task automatic alloc_n(input int n);
        alloc_valid_in = 1'b1;
        repeat (n) step();
        alloc_valid_in = 1'b0;
    endtask

    task automatic complete(input int ptr, input bit exc);
        cmpl_valid_in = 1'b1;
        cmpl_ptr_in   = IDX_W'(ptr);
        cmpl_exc_in   = exc;
        step();
        cmpl_valid_in = 1'b0;
        cmpl_exc_in   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (alloc_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", alloc_ready_out); end
        n_tests++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty_out); end
        n_tests++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full_out); end
        n_tests++; if (count_out !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count_out); end
        n_tests++; if (commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_cv: got %b want 0", commit_valid_out); end
        n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush_out); end
        n_tests++; if (alloc_ptr_out !== 7'd0) begin n_fail++; $display("FAIL rst_aptr: got %0d want 0", alloc_ptr_out); end
    endtask

    task automatic test_in_order();
        int order[3] = '{1, 0, 2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_valid_in = 1'b1;
            n_tests++; if (alloc_ptr_out !== IDX_W'(i)) begin n_fail++; $display("FAIL io_aptr: got %0d want %0d", alloc_ptr_out, i); end
            step();
        end
        alloc_valid_in = 1'b0;
        n_tests++; if (count_out !== 8'd3) begin n_fail++; $display("FAIL io_count3: got %0d want 3", count_out); end
        complete(order[0], 1'b0);
        n_tests++; if (commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL io_cv_early: got %b want 0", commit_valid_out); end
        complete(order[1], 1'b0);
        complete(order[2], 1'b0);
        exp_q = '{7'd0, 7'd1, 7'd2};
        commit_ready_in = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (commit_valid_out === 1'b1) begin
                n_tests++; if (commit_ptr_out !== exp_q[0]) begin n_fail++; $display("FAIL io_cptr: got %0d want %0d", commit_ptr_out, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            step();
        end
        commit_ready_in = 1'b0;
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL io_timeout: got %0d left want 0", exp_q.size()); end
        n_tests++; if (count_out !== 8'd0) begin n_fail++; $display("FAIL io_count0: got %0d want 0", count_out); end
        n_tests++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL io_empty: got %b want 1", empty_out); end
    endtask

    task automatic test_full_and_wrap();
        do_reset();
        alloc_n(N);
        n_tests++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL fu_full: got %b want 1", full_out); end
        n_tests++; if (alloc_ready_out !== 1'b0) begin n_fail++; $display("FAIL fu_ready: got %b want 0", alloc_ready_out); end
        n_tests++; if (count_out !== 8'd128) begin n_fail++; $display("FAIL fu_count: got %0d want 128", count_out); end
        alloc_n(1);
        n_tests++; if (count_out !== 8'd128) begin n_fail++; $display("FAIL fu_stall: got %0d want 128", count_out); end
        complete(0, 1'b0);
        alloc_valid_in  = 1'b1;
        commit_ready_in = 1'b1;
        n_tests++; if (commit_valid_out !== 1'b1) begin n_fail++; $display("FAIL wr_cv: got %b want 1", commit_valid_out); end
        step();
        commit_ready_in = 1'b0;
        n_tests++; if (count_out !== 8'd127) begin n_fail++; $display("FAIL wr_count127: got %0d want 127", count_out); end
        n_tests++; if (commit_ptr_out !== 7'd1) begin n_fail++; $display("FAIL wr_head: got %0d want 1", commit_ptr_out); end
        n_tests++; if (alloc_ready_out !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", alloc_ready_out); end
        n_tests++; if (alloc_ptr_out !== 7'd0) begin n_fail++; $display("FAIL wr_aptr: got %0d want 0", alloc_ptr_out); end
        step();
        alloc_valid_in = 1'b0;
        n_tests++; if (count_out !== 8'd128) begin n_fail++; $display("FAIL wr_refill: got %0d want 128", count_out); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(4);
        complete(0, 1'b1);
        n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL fl_early: got %b want 0", flush_out); end
        step();
        n_tests++; if (flush_out !== 1'b1) begin n_fail++; $display("FAIL fl_pulse: got %b want 1", flush_out); end
        n_tests++; if (flush_ptr_out !== 7'd0) begin n_fail++; $display("FAIL fl_ptr: got %0d want 0", flush_ptr_out); end
        n_tests++; if (alloc_ready_out !== 1'b0) begin n_fail++; $display("FAIL fl_ready: got %b want 0", alloc_ready_out); end
        step();
        n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL fl_width: got %b want 0", flush_out); end
        n_tests++; if (count_out !== 8'd0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", count_out); end
        alloc_n(3);
        n_tests++; if (count_out !== 8'd0) begin n_fail++; $display("FAIL fl_blocked: got %0d want 0", count_out); end
        redirect_ack_in = 1'b1;
        step();
        redirect_ack_in = 1'b0;
        n_tests++; if (alloc_ready_out !== 1'b1) begin n_fail++; $display("FAIL fl_resume: got %b want 1", alloc_ready_out); end
        alloc_n(1);
        n_tests++; if (count_out !== 8'd1) begin n_fail++; $display("FAIL fl_realloc: got %0d want 1", count_out); end
    endtask

    task automatic test_ignored_events();
        do_reset();
        alloc_n(2);
        complete(0, 1'b0);
        complete(0, 1'b1);
        step();
        n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL ig_redone: got flush %b want 0", flush_out); end
        n_tests++; if (commit_valid_out !== 1'b1) begin n_fail++; $display("FAIL ig_cv: got %b want 1", commit_valid_out); end
        complete(50, 1'b1);
        step();
        n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL ig_slot50: got flush %b want 0", flush_out); end
        issue_valid_in = 1'b1;
        issue_ptr_in   = 7'd0;
        step();
        issue_valid_in = 1'b0;
        n_tests++; if (commit_valid_out !== 1'b1) begin n_fail++; $display("FAIL ig_issue: got %b want 1", commit_valid_out); end
        commit_ready_in = 1'b1;
        step();
        commit_ready_in = 1'b0;
        n_tests++; if (count_out !== 8'd1) begin n_fail++; $display("FAIL ig_count: got %0d want 1", count_out); end
        n_tests++; if (commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL ig_cv1: got %b want 0", commit_valid_out); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        alloc_n(10);
        complete(0, 1'b1);
        step();
        step();
        n_tests++; if (alloc_ready_out !== 1'b0) begin n_fail++; $display("FAIL rw_wait: got ready %b want 0", alloc_ready_out); end
        @(negedge clk_in);
        rst_N_in = 1'b0;
        model_reset();
        #1;
        n_tests++; if (count_out !== 8'd0) begin n_fail++; $display("FAIL rw_count: got %0d want 0", count_out); end
        n_tests++; if (alloc_ready_out !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b want 1", alloc_ready_out); end
        n_tests++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL rw_empty: got %b want 1", empty_out); end
        n_tests++; if (alloc_ptr_out !== 7'd0) begin n_fail++; $display("FAIL rw_aptr: got %0d want 0", alloc_ptr_out); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL rw_flush: got %b want 0", flush_out); end
        end
        @(negedge clk_in);
        rst_N_in = 1'b1;
        step();
        n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL rw_flush_post: got %b want 0", flush_out); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            alloc_valid_in  = ($urandom_range(0, 9) < 6);
            commit_ready_in = ($urandom_range(0, 9) < 6);
            redirect_ack_in = ($urandom_range(0, 9) < 3);
            issue_valid_in  = ($urandom_range(0, 1) == 1);
            cmpl_valid_in   = ($urandom_range(0, 1) == 1);
            cmpl_exc_in     = ($urandom_range(0, 39) == 0);
            issue_ptr_in    = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                              IDX_W'(q[$urandom_range(0, q.size() - 1)]) : IDX_W'($urandom_range(0, N - 1));
            cmpl_ptr_in     = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                              IDX_W'(q[$urandom_range(0, q.size() - 1)]) : IDX_W'($urandom_range(0, N - 1));
            step();
            n_tests++; if (alloc_ready_out !== e_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, alloc_ready_out, e_ready()); end
            n_tests++; if (commit_valid_out !== e_cv()) begin n_fail++; $display("FAIL rnd_cv c%0d: got %b want %b", c, commit_valid_out, e_cv()); end
            n_tests++; if (count_out !== PTR_W'(q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count_out, q.size()); end
            n_tests++; if (full_out !== (q.size() == N)) begin n_fail++; $display("FAIL rnd_full c%0d: got %b", c, full_out); end
            n_tests++; if (empty_out !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c%0d: got %b", c, empty_out); end
            n_tests++; if (commit_ptr_out !== IDX_W'(m_head)) begin n_fail++; $display("FAIL rnd_head c%0d: got %0d want %0d", c, commit_ptr_out, m_head); end
            n_tests++; if (alloc_ptr_out !== IDX_W'(m_tail)) begin n_fail++; $display("FAIL rnd_tail c%0d: got %0d want %0d", c, alloc_ptr_out, m_tail); end
            n_tests++; if (flush_out !== (m_mode == M_FLUSH)) begin n_fail++; $display("FAIL rnd_flush c%0d: got %b", c, flush_out); end
            if (m_mode == M_FLUSH) begin
                n_tests++; if (flush_ptr_out !== IDX_W'(m_head)) begin n_fail++; $display("FAIL rnd_fptr c%0d: got %0d want %0d", c, flush_ptr_out, m_head); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_full_and_wrap();
        test_flush();
        test_ignored_events();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
